// File: rtl/imm_gen_pipe_if.sv
// Handshaked decode-stage bus for imm_gen_pipe: instruction/format/tag in, extended immediate out.
// The slave modport is the block's view; master is the view of whoever drives and consumes it.
interface imm_gen_pipe_if #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
);
    logic                  in_valid;
    logic                  in_ready;
    logic [31:0]           instr;
    logic [2:0]            ImmSrc;
    logic [TAG_WIDTH-1:0]  in_tag;
    logic                  flush;
    logic                  out_valid;
    logic                  out_ready;
    logic [DATA_WIDTH-1:0] ImmOp;
    logic [TAG_WIDTH-1:0]  out_tag;
    logic                  imm_illegal;

    modport slave (
        input  in_valid, instr, ImmSrc, in_tag, flush, out_ready,
        output in_ready, out_valid, ImmOp, out_tag, imm_illegal
    );

    modport master (
        output in_valid, instr, ImmSrc, in_tag, flush, out_ready,
        input  in_ready, out_valid, ImmOp, out_tag, imm_illegal
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// RV32I immediate generator (I/S/B/U/J) with a registered two-entry skid buffer.
// Outputs come straight from the main register; in_ready is the inverse of the skid flag.
module imm_gen_pipe #(
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 5
) (
    input logic          clk,
    input logic          rst,
    imm_gen_pipe_if.slave bus
);
    typedef enum logic [2:0] {
        FMT_I = 3'b000,
        FMT_S = 3'b001,
        FMT_B = 3'b010,
        FMT_U = 3'b011,
        FMT_J = 3'b100
    } fmt_e;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] imm;
        logic [TAG_WIDTH-1:0]  tag;
        logic                  illegal;
    } entry_t;

    logic signed [31:0] imm32;
    logic               src_illegal;
    entry_t             in_entry;
    entry_t             main_q, skid_q;
    logic               main_valid_q, skid_valid_q;
    logic               accept, pop;

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned (no latch).
    always_comb begin
        imm32       = '0;
        src_illegal = 1'b0;
        case (bus.ImmSrc)
            FMT_I:   imm32 = {{20{bus.instr[31]}}, bus.instr[31:20]};
            FMT_S:   imm32 = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
            FMT_B:   imm32 = {{19{bus.instr[31]}}, bus.instr[31], bus.instr[7],
                              bus.instr[30:25], bus.instr[11:8], 1'b0};
            FMT_U:   imm32 = {bus.instr[31:12], 12'b0};
            FMT_J:   imm32 = {{11{bus.instr[31]}}, bus.instr[31], bus.instr[19:12],
                              bus.instr[20], bus.instr[30:21], 1'b0};
            default: src_illegal = 1'b1;
        endcase
    end

    // Signed size cast extends bit 31 up to the datapath width.
    assign in_entry = '{imm: DATA_WIDTH'(imm32), tag: bus.in_tag, illegal: src_illegal};

    assign accept = bus.in_valid & ~skid_valid_q;
    assign pop    = main_valid_q & bus.out_ready;

    // NOTE: state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst || bus.flush) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            main_q       <= '0;
            skid_q       <= '0;
        end else if (!main_valid_q || pop) begin
            if (skid_valid_q) begin
                main_q       <= skid_q;
                main_valid_q <= 1'b1;
                skid_valid_q <= 1'b0;
            end else if (accept) begin
                main_q       <= in_entry;
                main_valid_q <= 1'b1;
            end else begin
                main_valid_q <= 1'b0;
            end
        end else if (accept) begin
            skid_q       <= in_entry;
            skid_valid_q <= 1'b1;
        end
    end

    assign bus.in_ready    = ~skid_valid_q;
    assign bus.out_valid   = main_valid_q;
    assign bus.ImmOp       = main_q.imm;
    assign bus.out_tag     = main_q.tag;
    assign bus.imm_illegal = main_q.illegal;
endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: a 32-bit and a 64-bit instance share one stimulus stream and are
// compared every cycle against a depth-2 FIFO reference whose immediates come from field arithmetic.
module tb_imm_gen_pipe;
    localparam int TW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, flush, out_ready;
    logic [31:0]   instr;
    logic [2:0]    src;
    logic [TW-1:0] tag;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imm_gen_pipe_if #(.DATA_WIDTH(32), .TAG_WIDTH(TW)) bus32 ();
    imm_gen_pipe_if #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) bus64 ();

    assign bus32.in_valid = in_valid;  assign bus64.in_valid = in_valid;
    assign bus32.instr    = instr;     assign bus64.instr    = instr;
    assign bus32.ImmSrc   = src;       assign bus64.ImmSrc   = src;
    assign bus32.in_tag   = tag;       assign bus64.in_tag   = tag;
    assign bus32.flush    = flush;     assign bus64.flush    = flush;
    assign bus32.out_ready = out_ready; assign bus64.out_ready = out_ready;

    imm_gen_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(TW)) dut32 (.clk(clk), .rst(rst), .bus(bus32));
    imm_gen_pipe #(.DATA_WIDTH(64), .TAG_WIDTH(TW)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    typedef struct {
        logic [63:0]   imm;
        logic [TW-1:0] tag;
        logic          ill;
    } exp_t;

    exp_t exp_q[$];
    logic was_reset = 1'b0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    // Immediate from the ISA field layout: gather bits, then sign-extend from the top field bit.
    function automatic logic [63:0] ref_imm(input logic [31:0] i, input logic [2:0] s, output logic ill);
        logic [63:0]        raw;
        int                 nb;
        logic signed [63:0] v;
        raw = 64'd0;
        nb  = 64;
        ill = 1'b0;
        case (s)
            3'd0: begin raw = 64'(i >> 20); nb = 12; end
            3'd1: begin raw = 64'(((i >> 25) << 5) | ((i >> 7) & 32'h1f)); nb = 12; end
            3'd2: begin
                raw = 64'((32'(i[31]) << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1));
                nb  = 13;
            end
            3'd3: begin raw = 64'(i & 32'hFFFF_F000); nb = 32; end
            3'd4: begin
                raw = 64'((32'(i[31]) << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1));
                nb  = 21;
            end
            default: ill = 1'b1;
        endcase
        v = $signed(raw << (64 - nb));
        v = v >>> (64 - nb);
        return ill ? 64'd0 : 64'(v);
    endfunction

    task automatic compare_model();
        check("out_valid32", 64'(bus32.out_valid), 64'(exp_q.size() != 0));
        check("out_valid64", 64'(bus64.out_valid), 64'(exp_q.size() != 0));
        check("in_ready32",  64'(bus32.in_ready),  64'(exp_q.size() < 2));
        check("in_ready64",  64'(bus64.in_ready),  64'(exp_q.size() < 2));
        if (exp_q.size() != 0) begin
            check("imm32",     64'(bus32.ImmOp),       {32'd0, exp_q[0].imm[31:0]});
            check("imm64",     bus64.ImmOp,            exp_q[0].imm);
            check("tag",       64'(bus32.out_tag),     64'(exp_q[0].tag));
            check("illegal",   64'(bus64.imm_illegal), 64'(exp_q[0].ill));
        end else if (was_reset) begin
            check("rst_imm32",   64'(bus32.ImmOp),       64'd0);
            check("rst_imm64",   bus64.ImmOp,            64'd0);
            check("rst_tag",     64'(bus64.out_tag),     64'd0);
            check("rst_illegal", 64'(bus32.imm_illegal), 64'd0);
        end
    endtask

    // One clock: predict the edge from current inputs, take the edge, then compare #1 later.
    task automatic cycle();
        exp_t e;
        logic acc, pp, ill;
        e.imm = ref_imm(instr, src, ill);
        e.tag = tag;
        e.ill = ill;
        acc = in_valid && (exp_q.size() < 2);
        pp  = out_ready && (exp_q.size() != 0);
        @(posedge clk);
        if (rst || flush) begin
            exp_q.delete();
        end else begin
            if (pp)  void'(exp_q.pop_front());
            if (acc) exp_q.push_back(e);
        end
        was_reset = rst;
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [31:0] i, input logic [2:0] s, input logic [TW-1:0] t);
        in_valid = 1'b1;
        instr    = i;
        src      = s;
        tag      = t;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        instr = '0; src = '0; tag = '0;
        cycle();
        cycle();
        rst = 1'b0;
        cycle();

        // I-type, then S and B back-to-back
        drive(32'hFFF00093, 3'b000, 5'd1); cycle();
        check("i_type32", 64'(bus32.ImmOp), 64'hFFFF_FFFF);
        check("i_type64", bus64.ImmOp, 64'hFFFF_FFFF_FFFF_FFFF);
        check("i_tag", 64'(bus32.out_tag), 64'd1);
        drive(32'hFE20AE23, 3'b001, 5'd2); cycle();
        check("s_type32", 64'(bus32.ImmOp), 64'hFFFF_FFFC);
        drive(32'hFE000CE3, 3'b010, 5'd3); cycle();
        check("b_type32", 64'(bus32.ImmOp), 64'hFFFF_FFF8);

        // U/J at 64 bits
        drive(32'h800000B7, 3'b011, 5'd4); cycle();
        check("u_neg64", bus64.ImmOp, 64'hFFFF_FFFF_8000_0000);
        drive(32'h0010006F, 3'b100, 5'd5); cycle();
        check("j_type64", bus64.ImmOp, 64'h0000_0000_0000_0800);
        drive(32'h123450B7, 3'b011, 5'd6); cycle();
        check("u_pos64", bus64.ImmOp, 64'h0000_0000_1234_5000);
        in_valid = 1'b0; cycle();

        // Backpressure: two accepted, third held upstream, then drained in order
        out_ready = 1'b0;
        drive(32'h0, 3'b000, 5'd1); cycle();
        drive(32'h0, 3'b000, 5'd2); cycle();
        check("bp_in_ready", 64'(bus32.in_ready), 64'd0);
        drive(32'h0, 3'b000, 5'd3); cycle();
        check("bp_hold_tag", 64'(bus32.out_tag), 64'd1);
        out_ready = 1'b1; cycle();
        check("bp_tag2", 64'(bus32.out_tag), 64'd2);
        cycle();
        check("bp_tag3", 64'(bus32.out_tag), 64'd3);
        in_valid = 1'b0; cycle();

        // Flush with two buffered and a concurrent input
        out_ready = 1'b0;
        drive(32'h00100093, 3'b000, 5'd7); cycle();
        drive(32'h00200093, 3'b000, 5'd8); cycle();
        drive(32'h00300093, 3'b000, 5'd9); flush = 1'b1; cycle();
        check("flush_valid", 64'(bus64.out_valid), 64'd0);
        check("flush_ready", 64'(bus64.in_ready), 64'd1);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1; cycle();
        check("flush_gone", 64'(bus32.out_valid), 64'd0);

        // Illegal format, then reset with entries buffered
        drive(32'hFFFFFFFF, 3'b101, 5'd10); cycle();
        check("illegal_imm", bus64.ImmOp, 64'd0);
        check("illegal_flag", 64'(bus64.imm_illegal), 64'd1);
        out_ready = 1'b0;
        drive(32'hFFF00093, 3'b000, 5'd11); cycle();
        rst = 1'b1; cycle();
        check("rst_valid", 64'(bus32.out_valid), 64'd0);
        rst = 1'b0; in_valid = 1'b0; cycle();

        // Randomized traffic with occasional flush and reset
        for (int n = 0; n < 3000; n++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            instr     = $urandom;
            src       = 3'($urandom % 8);
            tag       = TW'($urandom);
            flush     = ($urandom % 50) == 0;
            rst       = ($urandom % 200) == 0;
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
